ifetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the program counter and drives the synchronous instruction memory (one-cycle read latency, `en`-gated address/data capture). It issues at most one read per cycle, buffers returned words in a 2-entry skid FIFO, and presents `{pc, instr}` to decode with a valid/ready handshake. It discards wrong-path fetches on a redirect (branch, jump, exception) from later pipeline stages.

---
 rtl/ifetch_ctrl_if.sv | 25 ++
 rtl/ifetch_ctrl.sv | 97 +++++++++
 tb/tb_ifetch_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ifetch_ctrl_if.sv
// Fetch-unit bus: decode handshake, redirect request and instruction-memory port.
// master = fetch sequencer, slave = surrounding pipeline/memory.
interface ifetch_ctrl_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;
  logic        im_en;
  logic [31:0] im_addr;
  logic [31:0] im_dout;
  logic [31:0] im_addrout;

  modport master (
    input  redirect_valid, redirect_pc, out_ready, im_dout, im_addrout,
    output out_valid, out_pc, out_instr, out_fault, im_en, im_addr
  );

  modport slave (
    output redirect_valid, redirect_pc, out_ready, im_dout, im_addrout,
    input  out_valid, out_pc, out_instr, out_fault, im_en, im_addr
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one-cycle-latency memory reads
// under a 2-entry credit limit and presents {pc, instr, fault} through a skid FIFO.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_ctrl_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic        rsp_pending_q, rsp_pending_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] ent_pc_q    [2];
  logic [31:0] ent_pc_d    [2];
  logic [31:0] ent_instr_q [2];
  logic [31:0] ent_instr_d [2];
  logic        ent_fault_q [2];
  logic        ent_fault_d [2];

  logic        pop, push, issue, rsp_fault;
  logic [2:0]  credit;

  always_comb begin
    pop       = (count_q != 2'd0) && bus.out_ready;
    push      = rsp_pending_q && !bus.redirect_valid;
    rsp_fault = (bus.im_addrout[1:0] != 2'b00);
    // Occupancy the FIFO will have once the in-flight read lands, net of this pop.
    credit    = {1'b0, count_q} + {2'b00, rsp_pending_q} - {2'b00, pop};
    issue     = rst_n && !bus.redirect_valid && (credit < 3'd2);

    pc_d          = pc_q;
    rsp_pending_d = 1'b0;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    ent_pc_d      = ent_pc_q;
    ent_instr_d   = ent_instr_q;
    ent_fault_d   = ent_fault_q;

    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (issue) begin
        pc_d          = pc_q + 32'd4;
        rsp_pending_d = 1'b1;
      end
      if (push) begin
        ent_pc_d[wr_ptr_q]    = bus.im_addrout;
        ent_instr_d[wr_ptr_q] = rsp_fault ? '0 : bus.im_dout;
        ent_fault_d[wr_ptr_q] = rsp_fault;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pending_q <= 1'b0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        ent_pc_q[i]    <= '0;
        ent_instr_q[i] <= '0;
        ent_fault_q[i] <= 1'b0;
      end
    end else begin
      pc_q          <= pc_d;
      rsp_pending_q <= rsp_pending_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      ent_pc_q      <= ent_pc_d;
      ent_instr_q   <= ent_instr_d;
      ent_fault_q   <= ent_fault_d;
    end
  end

  always_comb begin
    bus.im_en     = issue;
    bus.im_addr   = pc_q;
    bus.out_valid = (count_q != 2'd0);
    bus.out_pc    = ent_pc_q[rd_ptr_q];
    bus.out_instr = ent_instr_q[rd_ptr_q];
    bus.out_fault = ent_fault_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: per-cycle vector table plus hand-written
// random-ready streaming and mid-run reset sequences.
module tb_ifetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ifetch_ctrl_if bus();

  ifetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h2408_0001 + {6'd0, a[11:2], 16'd0};
  endfunction

  // Synchronous instruction memory: one-cycle latency, en-gated capture.
  always_ff @(posedge clk) begin
    if (bus.im_en) begin
      bus.im_dout    <= word_at(bus.im_addr);
      bus.im_addrout <= bus.im_addr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    int unsigned reps;
    logic        ov;
    logic [31:0] opc;
    logic        flt;
    logic        en;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic redir, input logic [31:0] rpc, input logic rdy,
                     input int unsigned reps, input logic ov, input logic [31:0] opc,
                     input logic flt, input logic en, input logic [31:0] addr);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.reps = reps;
    v.ov = ov; v.opc = opc; v.flt = flt; v.en = en; v.addr = addr;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic ov, input logic [31:0] opc,
                               input logic flt, input logic en, input logic [31:0] addr);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, " im_en"}, 32'(bus.im_en), 32'(en));
    check({tag, " im_addr"}, bus.im_addr, addr);
    if (ov) begin
      check({tag, " out_pc"}, bus.out_pc, opc);
      check({tag, " out_fault"}, 32'(bus.out_fault), 32'(flt));
      check({tag, " out_instr"}, bus.out_instr, flt ? 32'h0 : word_at(opc));
    end
  endtask

  initial begin
    logic [31:0] exp_pc;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;

    //      redir rpc            rdy reps ov  out_pc        flt en  im_addr
    add(1'b0, 32'h0,         1'b1, 1,  1'b0, 32'h0,        1'b0, 1'b1, 32'h3000);       // C0
    add(1'b0, 32'h0,         1'b0, 1,  1'b0, 32'h0,        1'b0, 1'b1, 32'h3004);       // C1
    add(1'b0, 32'h0,         1'b0, 10, 1'b1, 32'h3000,     1'b0, 1'b0, 32'h3008);       // C2-C11 stall
    add(1'b0, 32'h0,         1'b1, 1,  1'b1, 32'h3000,     1'b0, 1'b1, 32'h3008);       // resume
    add(1'b0, 32'h0,         1'b1, 1,  1'b1, 32'h3004,     1'b0, 1'b1, 32'h300C);
    add(1'b0, 32'h0,         1'b1, 1,  1'b1, 32'h3008,     1'b0, 1'b1, 32'h3010);
    add(1'b0, 32'h0,         1'b1, 1,  1'b1, 32'h300C,     1'b0, 1'b1, 32'h3014);
    add(1'b1, 32'h3100,      1'b0, 1,  1'b1, 32'h3010,     1'b0, 1'b0, 32'h3018);       // redirect, read pending
    add(1'b0, 32'h0,         1'b0, 1,  1'b0, 32'h0,        1'b0, 1'b1, 32'h3100);
    add(1'b0, 32'h0,         1'b0, 1,  1'b0, 32'h0,        1'b0, 1'b1, 32'h3104);
    add(1'b0, 32'h0,         1'b1, 1,  1'b1, 32'h3100,     1'b0, 1'b1, 32'h3108);
    add(1'b1, 32'hFFFF_FFF8, 1'b1, 1,  1'b1, 32'h3104,     1'b0, 1'b0, 32'h310C);       // redirect with pop
    add(1'b0, 32'h0,         1'b1, 1,  1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FFF8);
    add(1'b0, 32'h0,         1'b1, 1,  1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FFFC);
    add(1'b0, 32'h0,         1'b1, 1,  1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'h0);
    add(1'b0, 32'h0,         1'b1, 1,  1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h4);
    add(1'b1, 32'h5000,      1'b1, 1,  1'b1, 32'h0,        1'b0, 1'b0, 32'h8);          // back-to-back
    add(1'b1, 32'h3102,      1'b1, 1,  1'b0, 32'h0,        1'b0, 1'b0, 32'h5000);
    add(1'b0, 32'h0,         1'b1, 1,  1'b0, 32'h0,        1'b0, 1'b1, 32'h3102);
    add(1'b0, 32'h0,         1'b1, 1,  1'b0, 32'h0,        1'b0, 1'b1, 32'h3106);
    add(1'b0, 32'h0,         1'b1, 1,  1'b1, 32'h3102,     1'b1, 1'b1, 32'h310A);       // misaligned
    add(1'b0, 32'h0,         1'b1, 1,  1'b1, 32'h3106,     1'b1, 1'b1, 32'h310E);
    add(1'b0, 32'h0,         1'b1, 1,  1'b1, 32'h310A,     1'b1, 1'b1, 32'h3112);

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check_outputs("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h3000);
    check("reset out_pc", bus.out_pc, 32'h0);
    check("reset out_instr", bus.out_instr, 32'h0);
    check("reset out_fault", 32'(bus.out_fault), 32'h0);

    // Vector table; reset releases together with the first vector (C0)
    foreach (vecs[i]) begin
      for (int unsigned r = 0; r < vecs[i].reps; r++) begin
        @(posedge clk);
        #2;
        rst_n              = 1'b1;
        bus.redirect_valid = vecs[i].redir;
        bus.redirect_pc    = vecs[i].rpc;
        bus.out_ready      = vecs[i].rdy;
        #1;
        check_outputs($sformatf("vec%0d", i), vecs[i].ov, vecs[i].opc, vecs[i].flt,
                      vecs[i].en, vecs[i].addr);
      end
    end

    // Streaming with random ready: every pop must continue the faulted sequence in order
    exp_pc = 32'h310E;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #2;
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'($urandom_range(0, 1));
      #1;
      if (bus.out_valid && bus.out_ready) begin
        check("stream out_pc", bus.out_pc, exp_pc);
        check("stream out_fault", 32'(bus.out_fault), 32'h1);
        check("stream out_instr", bus.out_instr, 32'h0);
        exp_pc = exp_pc + 32'd4;
      end
    end

    // Asynchronous reset mid-stream for one cycle
    @(posedge clk);
    #2;
    rst_n         = 1'b0;
    bus.out_ready = 1'($urandom_range(0, 1));
    #1;
    check_outputs("midrst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h3000);
    check("midrst out_pc", bus.out_pc, 32'h0);
    check("midrst out_instr", bus.out_instr, 32'h0);

    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #2;
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check_outputs($sformatf("restart C%0d", k), k >= 2,
                    32'h3000 + 32'(4 * (k - 2)), 1'b0, 1'b1, 32'h3000 + 32'(4 * k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
